// File: rtl/integer_serializer_pkg.sv
// Shared widths, ASCII constants and FSM encoding for the integer serializer.
package integer_serializer_pkg;
  localparam int CHAR_BITES          = 8;
  localparam int ATTRIBUTE_VAL_BITES = 10;

  localparam logic [CHAR_BITES-1:0] ASCII_ZERO  = 8'h30;
  localparam logic [CHAR_BITES-1:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DIVIDE = 3'd1,
    EMIT   = 3'd2,
    TERM   = 3'd3,
    DONE   = 3'd4
  } ser_state_t;

  // Place index 0..3 selects 1000, 100, 10, 1.
  function automatic logic [ATTRIBUTE_VAL_BITES-1:0] place_value(input logic [1:0] idx);
    case (idx)
      2'd0:    place_value = 10'd1000;
      2'd1:    place_value = 10'd100;
      2'd2:    place_value = 10'd10;
      default: place_value = 10'd1;
    endcase
  endfunction
endpackage

// File: rtl/integer_serializer_digit_to_char.sv
// Combinational BCD digit to ASCII conversion (inverse of char_to_int).
module digit_to_char
  import integer_serializer_pkg::*;
(
  input  logic [3:0]            digit,
  output logic [CHAR_BITES-1:0] char_code
);
  assign char_code = ASCII_ZERO + {4'd0, digit};
endmodule

// File: rtl/integer_serializer.sv
// Emits a 10-bit unsigned value as decimal ASCII, MSD first, via ready/valid.
// Optional trailing space enabled by INTEGER_SERIALIZER_SPACE_TERM_EN.
module integer_serializer
  import integer_serializer_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [ATTRIBUTE_VAL_BITES-1:0] value,
  input  logic                           char_ready,
  output logic [CHAR_BITES-1:0]          char,
  output logic                           char_valid,
  output logic                           busy,
  output logic                           has_finished
);
  ser_state_t                     state, state_next;
  logic [ATTRIBUTE_VAL_BITES-1:0] remainder;
  logic [1:0]                     place_idx;
  logic [3:0]                     digit;
  logic                           seen_nonzero;
  logic [CHAR_BITES-1:0]          digit_char;

  logic [ATTRIBUTE_VAL_BITES-1:0] place_val;
  logic                           ge, last_place, resolve_emit;

  assign place_val    = place_value(place_idx);
  assign ge           = (remainder >= place_val);
  assign last_place   = (place_idx == 2'd3);
  assign resolve_emit = (digit != 4'd0) || seen_nonzero || last_place;

  digit_to_char u_digit_to_char (
    .digit     (digit),
    .char_code (digit_char)
  );

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      remainder    <= '0;
      place_idx    <= 2'd0;
      digit        <= 4'd0;
      seen_nonzero <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          remainder    <= value;
          place_idx    <= 2'd0;
          digit        <= 4'd0;
          seen_nonzero <= 1'b0;
        end
        DIVIDE: begin
          if (ge) begin
            remainder <= remainder - place_val;
            digit     <= digit + 4'd1;
            // Ninth subtraction resolves the digit in the same cycle.
            if (digit == 4'd8) seen_nonzero <= 1'b1;
          end else if (resolve_emit) begin
            seen_nonzero <= 1'b1;
          end else begin
            place_idx <= place_idx + 2'd1;
            digit     <= 4'd0;
          end
        end
        EMIT: if (char_ready && !last_place) begin
          place_idx <= place_idx + 2'd1;
          digit     <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = DIVIDE;
      DIVIDE: begin
        if (ge) begin
          if (digit == 4'd8) state_next = EMIT;
        end else if (resolve_emit) begin
          state_next = EMIT;
        end
      end
      EMIT: if (char_ready) begin
        if (last_place)
`ifdef INTEGER_SERIALIZER_SPACE_TERM_EN
          state_next = TERM;
`else
          state_next = DONE;
`endif
        else
          state_next = DIVIDE;
      end
      TERM:    if (char_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    char         = '0;
    char_valid   = 1'b0;
    busy         = 1'b0;
    has_finished = 1'b0;
    case (state)
      DIVIDE: busy = 1'b1;
      EMIT: begin
        busy       = 1'b1;
        char_valid = 1'b1;
        char       = digit_char;
      end
      TERM: begin
        busy       = 1'b1;
        char_valid = 1'b1;
        char       = ASCII_SPACE;
      end
      DONE:    has_finished = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: doc/integer_serializer.md
INTEGER_SERIALIZER -- requirements
Module: integer_serializer

Interface
REQ-001 Parameters: none; widths SHALL come from the shared package constants CHAR_BITES (8) and ATTRIBUTE_VAL_BITES (10).
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to serialize value; sampled only in IDLE.
REQ-005 value  input  10  unsigned integer to emit (0..1023); captured when start is accepted.
REQ-006 char_ready  input  1  downstream accepts char this cycle.
REQ-007 char  output  8  ASCII character being offered.
REQ-008 char_valid  output  1  char is valid; transfer occurs on a rising edge with char_valid and char_ready both high.
REQ-009 busy  output  1  high from start acceptance until has_finished is asserted.
REQ-010 has_finished  output  1  one-cycle pulse after the last character transfers.

Function
REQ-011 The block SHALL emit the decimal representation of value, most significant digit first, as ASCII "0"-"9", with no leading zeros.
REQ-012 A value of 0 SHALL emit exactly one "0".
REQ-013 FSM states: IDLE, DIVIDE, EMIT, TERM, DONE.
REQ-014 IDLE: on start=1, capture value into a 10-bit remainder, set place index to 1000, clear the seen_nonzero flag, set digit=0, go to DIVIDE, and assert busy next cycle.
REQ-015 DIVIDE: each cycle, if remainder >= place, subtract place and increment digit (4-bit, max 9); otherwise leave the digit resolved.
REQ-016 Resolved digit: if digit!=0, seen_nonzero=1, or place==1, go to EMIT; otherwise advance place (1000->100->10->1) with digit=0 and stay in DIVIDE.
REQ-017 EMIT: char_valid=1 and char=digit+0x30, both held stable until transfer; on transfer, advance place and go to DIVIDE, or, if place was 1, go to TERM (macro on) or DONE (macro off).
REQ-018 TERM: char_valid=1 and char=0x20 (" ") until transfer, then go to DONE.
REQ-019 DONE: has_finished=1 for exactly one cycle, busy=0, return to IDLE.
REQ-020 char_valid SHALL NOT drop, and char SHALL NOT change, while un-transferred; char_ready while char_valid=0 has no effect.
REQ-021 start while busy SHALL be ignored; value changes after capture SHALL NOT affect output.
REQ-022 start in the DONE cycle SHALL be ignored; start is accepted no earlier than the following IDLE cycle.
REQ-023 Worst-case latency with char_ready tied high: at most 9 DIVIDE cycles per place plus 1 EMIT cycle per emitted character.

Reset
REQ-024 Reset SHALL force IDLE asynchronously, with char_valid=0, busy=0, has_finished=0, char=0x00, remainder=0, seen_nonzero=0, from any state including mid-character.
REQ-025 After reset deassertion, the first accepted start SHALL begin a fresh conversion; no partial character SHALL be replayed.

Configuration
REQ-026 Macro INTEGER_SERIALIZER_SPACE_TERM_EN: when defined, a trailing " " (0x20) SHALL be emitted after the last digit, matching the space-terminated form the attribute parser consumes.
REQ-027 Without the macro, TERM SHALL be unreachable and DONE SHALL follow the final digit transfer directly.

Structure
REQ-028 The shared package SHALL hold CHAR_BITES, ATTRIBUTE_VAL_BITES, ASCII_ZERO (0x30), ASCII_SPACE (0x20), and the FSM state encoding.
REQ-029 One sub-module, digit_to_char (4-bit digit -> 8-bit ASCII, combinational), SHALL perform digit conversion as the inverse of char_to_int.

Verification
REQ-030 value=0, start, ready=1 -> chars "0"," ", then has_finished pulse; busy low afterwards.
REQ-031 value=1023, ready=1 -> "1","0","2","3"," " in order; value=100 -> "1","0","0"," " (internal zeros kept).
REQ-032 value=7, ready low for 3 cycles during EMIT -> "7" held with char_valid high for 4 cycles; single transfer only.
REQ-033 value=512 accepted, then start with value=99 while busy -> output is only "5","1","2"," ".
REQ-034 Reset asserted during EMIT of value=345 -> char_valid=0 immediately; next start with value=6 -> "6"," ".
REQ-035 Build without INTEGER_SERIALIZER_SPACE_TERM_EN, value=42 -> "4","2", then has_finished; no 0x20 ever emitted.
